// File: rtl/sp_ram_banked_wrap.sv
// sp_ram_banked_wrap: single-port RAM wrapper for core memory ports.
// Storage is split into word-interleaved banks, each built from byte lanes.
// A zero sweep runs after reset before the first grant.
// Requests use a req/gnt/rvalid handshake; rvalid arrives 1 + OUT_REG cycles after accept.
// Out-of-range accesses return err_o without touching the arrays.
// A bypass request returns its own write data without writing the array.
module sp_ram_banked_wrap #(
  parameter int unsigned RAM_SIZE   = 32768,
  parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned INIT_ZERO  = 1
) (
  input  logic                    clk,
  input  logic                    rstn_i,
  input  logic                    en_i,
  output logic                    gnt_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    bypass_en_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic                    init_done_o
);

  // Geometry
  localparam int unsigned NumBytes  = DATA_WIDTH / 8;
  localparam int unsigned OffsetW   = $clog2(NumBytes);
  localparam int unsigned BankW     = $clog2(NUM_BANKS);
  localparam int unsigned BankWords = RAM_SIZE / (NUM_BANKS * NumBytes);
  localparam int unsigned RowW      = (BankWords > 1) ? $clog2(BankWords) : 1;
  localparam int unsigned SelW      = (BankW > 0) ? BankW : 1;

  localparam logic [RowW-1:0]       RowLast  = RowW'(BankWords - 1);
  localparam logic [ADDR_WIDTH:0]   RamLimit = (ADDR_WIDTH + 1)'(RAM_SIZE);

  // Top-level state
  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  // Where the response data of an accepted request comes from
  localparam logic [1:0] SrcZero = 2'd0;
  localparam logic [1:0] SrcRam  = 2'd1;
  localparam logic [1:0] SrcByp  = 2'd2;
  localparam logic [1:0] SrcErr  = 2'd3;

  // Elaboration-time parameter checks
  if ((NUM_BANKS == 0) || ((NUM_BANKS & (NUM_BANKS - 1)) != 0)) begin : g_bad_num_banks
    $error("sp_ram_banked_wrap: NUM_BANKS must be a power of 2");
  end
  if ((DATA_WIDTH == 0) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_data_width
    $error("sp_ram_banked_wrap: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if ((RAM_SIZE % (NUM_BANKS * NumBytes)) != 0) begin : g_bad_ram_size
    $error("sp_ram_banked_wrap: RAM_SIZE must be a multiple of NUM_BANKS*DATA_WIDTH/8");
  end
  if (ADDR_WIDTH < $clog2(RAM_SIZE)) begin : g_bad_addr_width
    $error("sp_ram_banked_wrap: ADDR_WIDTH too small for RAM_SIZE");
  end

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [ADDR_WIDTH-1:0] row_full;
  logic [RowW-1:0]       row_idx;
  logic [SelW-1:0]       bank_sel;
  logic                  oor;
  logic                  unused_row_hi;

  assign word_idx = addr_i >> OffsetW;
  assign row_full = word_idx >> BankW;
  assign row_idx  = row_full[RowW-1:0];
  assign bank_sel = (NUM_BANKS > 1) ? word_idx[SelW-1:0] : '0;
  // One extra bit so the comparison stays meaningful when ADDR_WIDTH == log2(RAM_SIZE)
  assign oor      = ({1'b0, addr_i} >= RamLimit);
  // Row bits above the bank depth only matter for the range check
  assign unused_row_hi = ^row_full;

  // ---------------------------------------------------------------------------
  // INIT -> RUN sequencing
  // ---------------------------------------------------------------------------
  logic [0:0]      state_q, state_d;
  logic [RowW-1:0] cnt_q, cnt_d;

  // Next-state: sweep every row once (or a single idle cycle without zeroing), then run
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StInit) begin
      if ((INIT_ZERO == 0) || (cnt_q == RowLast)) begin
        state_d = StRun;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State and sweep counter registers
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Grant is purely a function of state, so requests raised during INIT simply wait
  assign gnt_o       = (state_q == StRun);
  assign init_done_o = (state_q == StRun);

  // ---------------------------------------------------------------------------
  // Array access control
  // ---------------------------------------------------------------------------
  logic accept;
  logic arr_wr;
  logic arr_rd;
  logic init_wr;

  assign accept  = en_i & gnt_o;
  assign arr_wr  = accept & we_i & ~bypass_en_i & ~oor;
  assign arr_rd  = accept & ~we_i & ~bypass_en_i & ~oor;
  assign init_wr = (state_q == StInit) && (INIT_ZERO != 0);

  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_rdata;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic bank_hit;
    assign bank_hit = (bank_sel == SelW'(b));

    for (genvar l = 0; l < NumBytes; l++) begin : g_lane
      logic [7:0] mem [BankWords];
      logic [7:0] rd_q;

      // Byte lane: zero sweep in INIT, byte-enabled write and registered read in RUN
      always_ff @(posedge clk) begin
        if (init_wr) begin
          mem[cnt_q] <= 8'h00;
        end else if (arr_wr && bank_hit && be_i[l]) begin
          mem[row_idx] <= wdata_i[l*8 +: 8];
        end
        if (arr_rd && bank_hit) begin
          rd_q <= mem[row_idx];
        end
      end

      assign bank_rdata[b][l*8 +: 8] = rd_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Response pipeline
  // ---------------------------------------------------------------------------
  logic [1:0]            src_d;
  logic                  rsp_valid_q;
  logic [1:0]            rsp_src_q;
  logic [SelW-1:0]       rsp_bank_q;
  logic [DATA_WIDTH-1:0] rsp_wdata_q;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  // Classify the request; range error wins over bypass
  always_comb begin
    if (oor) begin
      src_d = SrcErr;
    end else if (bypass_en_i) begin
      src_d = SrcByp;
    end else if (we_i) begin
      src_d = SrcZero;
    end else begin
      src_d = SrcRam;
    end
  end

  // Response metadata only changes on accept, so the output holds between responses
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      rsp_valid_q <= 1'b0;
      rsp_src_q   <= SrcZero;
      rsp_bank_q  <= '0;
      rsp_wdata_q <= '0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_src_q  <= src_d;
        rsp_bank_q <= bank_sel;
        if (bypass_en_i) begin
          rsp_wdata_q <= wdata_i;
        end
      end
    end
  end

  // Select response data from the addressed bank, the bypassed word, or zero
  always_comb begin
    rsp_data = '0;
    case (rsp_src_q)
      SrcRam:  rsp_data = bank_rdata[rsp_bank_q];
      SrcByp:  rsp_data = rsp_wdata_q;
      default: rsp_data = '0;
    endcase
  end

  assign rsp_err = (rsp_src_q == SrcErr);

  if (OUT_REG != 0) begin : g_out_reg
    logic                  out_valid_q;
    logic                  out_err_q;
    logic [DATA_WIDTH-1:0] out_rdata_q;

    // Extra output stage; data and err only load with a valid response
    always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
        out_valid_q <= 1'b0;
        out_err_q   <= 1'b0;
        out_rdata_q <= '0;
      end else begin
        out_valid_q <= rsp_valid_q;
        if (rsp_valid_q) begin
          out_rdata_q <= rsp_data;
          out_err_q   <= rsp_err;
        end
      end
    end

    assign rvalid_o = out_valid_q;
    assign rdata_o  = out_rdata_q;
    assign err_o    = out_err_q;
  end else begin : g_no_out_reg
    assign rvalid_o = rsp_valid_q;
    assign rdata_o  = rsp_data;
    assign err_o    = rsp_err;
  end

endmodule

// File: tb/tb_sp_ram_banked_wrap.sv
// Testbench for sp_ram_banked_wrap with a flat word-array reference model.
// DUT: ADDR_WIDTH=16 (so out-of-range addresses exist), other parameters default.
module tb_sp_ram_banked_wrap;

  localparam int unsigned RamSize   = 32768;
  localparam int unsigned NumWords  = RamSize / 4;
  localparam int unsigned BankWords = RamSize / 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        gnt;
  logic [15:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        byp;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        init_done;

  always #5 clk = ~clk;

  sp_ram_banked_wrap #(
    .RAM_SIZE  (RamSize),
    .ADDR_WIDTH(16),
    .DATA_WIDTH(32),
    .NUM_BANKS (4),
    .OUT_REG   (0),
    .INIT_ZERO (1)
  ) u_dut (
    .clk        (clk),
    .rstn_i     (rstn),
    .en_i       (en),
    .gnt_o      (gnt),
    .addr_i     (addr),
    .we_i       (we),
    .be_i       (be),
    .wdata_i    (wdata),
    .bypass_en_i(byp),
    .rvalid_o   (rvalid),
    .rdata_o    (rdata),
    .err_o      (err),
    .init_done_o(init_done)
  );

  // Reference model: flat word memory plus the last delivered response
  logic [31:0] ref_mem [NumWords];
  logic [31:0] last_rdata;
  logic        last_err;
  int          total = 0;
  int          bad   = 0;

  task automatic model_reset();
    for (int i = 0; i < NumWords; i++) ref_mem[i] = 32'h0;
    last_rdata = 32'h0;
    last_err   = 1'b0;
  endtask

  task automatic model_accept(input logic m_we, input logic [15:0] m_addr,
                              input logic [3:0] m_be, input logic [31:0] m_wd,
                              input logic m_byp, output logic [31:0] exp_d,
                              output logic exp_e);
    int unsigned w;
    w     = 32'(m_addr) / 4;
    exp_d = 32'h0;
    exp_e = 1'b0;
    if (32'(m_addr) >= RamSize) begin
      exp_e = 1'b1;
    end else if (m_byp) begin
      exp_d = m_wd;
    end else if (m_we) begin
      for (int i = 0; i < 4; i++) begin
        if (m_be[i]) ref_mem[w][i*8 +: 8] = m_wd[i*8 +: 8];
      end
    end else begin
      exp_d = ref_mem[w];
    end
    last_rdata = exp_d;
    last_err   = exp_e;
  endtask

  task automatic drive(input logic e, input logic w, input logic [15:0] a,
                       input logic [3:0] b, input logic [31:0] d, input logic y);
    en    = e;
    we    = w;
    addr  = a;
    be    = b;
    wdata = d;
    byp   = y;
  endtask

  // One clock in RUN: the model grants every request; returns expected response
  task automatic step(output logic acc, output logic [31:0] exp_d, output logic exp_e);
    logic        s_we, s_byp;
    logic [15:0] s_addr;
    logic [3:0]  s_be;
    logic [31:0] s_wd;
    acc    = en;
    s_we   = we;
    s_byp  = byp;
    s_addr = addr;
    s_be   = be;
    s_wd   = wdata;
    @(posedge clk);
    #1;
    exp_d = last_rdata;
    exp_e = last_err;
    if (acc) model_accept(s_we, s_addr, s_be, s_wd, s_byp, exp_d, exp_e);
  endtask

  task automatic test_reset();
    int   low_cnt;
    logic saw_rv;
    logic acc;
    logic [31:0] d;
    logic e;
    rstn = 1'b1;
    drive(1'b1, 1'b0, 16'($urandom_range(0, RamSize - 1)), 4'hF, 32'h0, 1'b0);
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({gnt, rvalid, err, init_done, rdata} !== 36'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", {gnt, rvalid, err, init_done, rdata});
    end
    model_reset();
    rstn    = 1'b1;
    low_cnt = 0;
    saw_rv  = 1'b0;
    while (!gnt && low_cnt < 3000) begin
      low_cnt++;
      if (rvalid) saw_rv = 1'b1;
      @(posedge clk);
      #1;
    end
    total++;
    if (low_cnt != BankWords) begin
      bad++;
      $display("FAIL init_length got=%0d exp=%0d", low_cnt, BankWords);
    end
    total++;
    if (saw_rv !== 1'b0) begin
      bad++;
      $display("FAIL init_rvalid got=%b exp=0", saw_rv);
    end
    total++;
    if (init_done !== 1'b1) begin
      bad++;
      $display("FAIL init_done got=%b exp=1", init_done);
    end
    // The request held through INIT is accepted in the first RUN cycle
    step(acc, d, e);
    total++;
    if (rvalid !== 1'b1 || rdata !== d || err !== e) begin
      bad++;
      $display("FAIL held_first_read got=%b/%h/%b exp=1/%h/%b", rvalid, rdata, err, d, e);
    end
  endtask

  task automatic test_init_zero();
    logic acc;
    logic [31:0] d;
    logic e;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 16'($urandom_range(0, RamSize - 1)), 4'hF, 32'h0, 1'b0);
      step(acc, d, e);
      total++;
      if (rvalid !== acc || rdata !== d || err !== e) begin
        bad++;
        $display("FAIL init_zero[%0d] got=%b/%h/%b exp=%b/%h/%b",
                 i, rvalid, rdata, err, acc, d, e);
      end
    end
  endtask

  task automatic test_partial_write();
    logic acc;
    logic [31:0] d;
    logic e;
    drive(1'b1, 1'b1, 16'h0010, 4'b0101, 32'hDEADBEEF, 1'b0);
    total++;
    if (gnt !== 1'b1) begin
      bad++;
      $display("FAIL partial_gnt got=%b exp=1", gnt);
    end
    step(acc, d, e);
    total++;
    if (rvalid !== 1'b1 || rdata !== 32'h0 || err !== 1'b0) begin
      bad++;
      $display("FAIL partial_wr_rsp got=%b/%h/%b exp=1/0/0", rvalid, rdata, err);
    end
    drive(1'b1, 1'b0, 16'h0010, 4'hF, 32'h0, 1'b0);
    step(acc, d, e);
    total++;
    if (rvalid !== 1'b1 || rdata !== 32'h00AD00EF || rdata !== d) begin
      bad++;
      $display("FAIL partial_rd got=%b/%h exp=1/00ad00ef", rvalid, rdata);
    end
    drive(1'b0, 1'b0, 16'h0000, 4'h0, 32'hFFFFFFFF, 1'b0);
    step(acc, d, e);
    total++;
    if (rvalid !== 1'b0 || rdata !== d || err !== e) begin
      bad++;
      $display("FAIL partial_hold got=%b/%h/%b exp=0/%h/%b", rvalid, rdata, err, d, e);
    end
  endtask

  task automatic test_back_to_back();
    logic acc;
    logic [31:0] d;
    logic e;
    int pulses;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drive(1'b1, 1'b1, 16'(i * 4), 4'hF, $urandom, 1'b0);
      else       drive(1'b1, 1'b0, 16'((i - 4) * 4), 4'hF, 32'h0, 1'b0);
      total++;
      if (gnt !== 1'b1) begin
        bad++;
        $display("FAIL b2b_gnt[%0d] got=%b exp=1", i, gnt);
      end
      step(acc, d, e);
      if (rvalid) pulses++;
      total++;
      if (rvalid !== 1'b1 || rdata !== d || err !== e) begin
        bad++;
        $display("FAIL b2b_rsp[%0d] got=%b/%h/%b exp=1/%h/%b", i, rvalid, rdata, err, d, e);
      end
    end
    drive(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
    step(acc, d, e);
    if (rvalid) pulses++;
    total++;
    if (pulses != 8) begin
      bad++;
      $display("FAIL b2b_pulses got=%0d exp=8", pulses);
    end
  endtask

  task automatic test_bypass();
    logic acc;
    logic [31:0] d;
    logic e;
    drive(1'b1, 1'b1, 16'h0020, 4'hF, 32'hCAFEF00D, 1'b0);
    step(acc, d, e);
    drive(1'b1, 1'b1, 16'h0020, 4'hF, 32'h12345678, 1'b1);
    step(acc, d, e);
    total++;
    if (rvalid !== 1'b1 || rdata !== 32'h12345678 || rdata !== d || err !== 1'b0) begin
      bad++;
      $display("FAIL bypass_wr got=%b/%h/%b exp=1/12345678/0", rvalid, rdata, err);
    end
    drive(1'b1, 1'b0, 16'h0020, 4'hF, 32'h0BADC0DE, 1'b1);
    step(acc, d, e);
    total++;
    if (rvalid !== 1'b1 || rdata !== d) begin
      bad++;
      $display("FAIL bypass_rd got=%b/%h exp=1/%h", rvalid, rdata, d);
    end
    drive(1'b1, 1'b0, 16'h0020, 4'hF, 32'h0, 1'b0);
    step(acc, d, e);
    total++;
    if (rvalid !== 1'b1 || rdata !== 32'hCAFEF00D || rdata !== d) begin
      bad++;
      $display("FAIL bypass_no_write got=%b/%h exp=1/cafef00d", rvalid, rdata);
    end
  endtask

  task automatic test_out_of_range();
    logic acc;
    logic [31:0] d;
    logic e;
    drive(1'b1, 1'b1, 16'h8010, 4'hF, 32'hFFFFFFFF, 1'b0);
    step(acc, d, e);
    total++;
    if (rvalid !== 1'b1 || err !== 1'b1 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL oor_wr got=%b/%h/%b exp=1/0/1", rvalid, rdata, err);
    end
    drive(1'b1, 1'b0, 16'h8000, 4'hF, 32'h0, 1'b0);
    step(acc, d, e);
    total++;
    if (rvalid !== 1'b1 || err !== 1'b1 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL oor_rd got=%b/%h/%b exp=1/0/1", rvalid, rdata, err);
    end
    drive(1'b1, 1'b1, 16'h9000, 4'hF, 32'h77777777, 1'b1);
    step(acc, d, e);
    total++;
    if (rvalid !== 1'b1 || err !== 1'b1 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL oor_bypass got=%b/%h/%b exp=1/0/1", rvalid, rdata, err);
    end
    drive(1'b1, 1'b0, 16'h0010, 4'hF, 32'h0, 1'b0);
    step(acc, d, e);
    total++;
    if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== d) begin
      bad++;
      $display("FAIL oor_next_in_range got=%b/%h/%b exp=1/%h/0", rvalid, rdata, err, d);
    end
  endtask

  task automatic test_raw();
    logic acc;
    logic [31:0] d;
    logic e;
    logic [15:0] a;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom_range(0, NumWords - 1) * 4);
      drive(1'b1, 1'b1, a, 4'($urandom), $urandom, 1'b0);
      step(acc, d, e);
      drive(1'b1, 1'b0, a, 4'hF, 32'h0, 1'b0);
      step(acc, d, e);
      total++;
      if (rvalid !== 1'b1 || rdata !== d || err !== 1'b0) begin
        bad++;
        $display("FAIL raw[%0d] addr=%h got=%b/%h/%b exp=1/%h/0", i, a, rvalid, rdata, err, d);
      end
    end
  endtask

  task automatic test_random();
    logic acc;
    logic [31:0] d;
    logic e;
    logic [15:0] a;
    int r;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10)      a = 16'($urandom_range(RamSize, 65535));
      else if (r < 60) a = 16'($urandom_range(0, 63));
      else             a = 16'($urandom_range(0, RamSize - 1));
      drive($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom,
            $urandom_range(0, 9) == 0);
      total++;
      if (gnt !== 1'b1) begin
        bad++;
        $display("FAIL rand_gnt[%0d] got=%b exp=1", i, gnt);
      end
      step(acc, d, e);
      total++;
      if (rvalid !== acc || rdata !== d || err !== e) begin
        bad++;
        $display("FAIL rand_rsp[%0d] addr=%h got=%b/%h/%b exp=%b/%h/%b",
                 i, a, rvalid, rdata, err, acc, d, e);
      end
    end
    drive(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic acc;
    logic [31:0] d;
    logic e;
    int   low_cnt;
    logic saw_rv;
    drive(1'b1, 1'b1, 16'h0040, 4'hF, 32'h5A5A5A5A, 1'b0);
    step(acc, d, e);
    drive(1'b1, 1'b0, 16'h0040, 4'hF, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    total++;
    if ({gnt, rvalid, err, init_done, rdata} !== 36'h0) begin
      bad++;
      $display("FAIL midrst_async got=%h exp=0", {gnt, rvalid, err, init_done, rdata});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if ({gnt, rvalid, err, init_done, rdata} !== 36'h0) begin
        bad++;
        $display("FAIL midrst_hold[%0d] got=%h exp=0", i, {gnt, rvalid, err, init_done, rdata});
      end
    end
    model_reset();
    rstn    = 1'b1;
    low_cnt = 0;
    saw_rv  = 1'b0;
    while (!gnt && low_cnt < 3000) begin
      low_cnt++;
      if (rvalid) saw_rv = 1'b1;
      @(posedge clk);
      #1;
    end
    total++;
    if (low_cnt != BankWords || saw_rv !== 1'b0) begin
      bad++;
      $display("FAIL midrst_reinit got=%0d/%b exp=%0d/0", low_cnt, saw_rv, BankWords);
    end
    step(acc, d, e);
    total++;
    if (rvalid !== 1'b1 || rdata !== d || err !== 1'b0) begin
      bad++;
      $display("FAIL midrst_rezero got=%b/%h/%b exp=1/%h/0", rvalid, rdata, err, d);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
    test_reset();
    test_init_zero();
    test_partial_write();
    test_back_to_back();
    test_bypass();
    test_out_of_range();
    test_raw();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
